// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//
// Purpose:
//   Serial bit-pattern detector for a 1-bit input stream. The pattern, the
//   per-bit don't-care mask and the overlap mode are programmable at runtime.
//   A combinational (Mealy) match pulse is raised in the same cycle as the
//   completing bit, and a saturating counter tallies matches.
//
// Parameters:
//   NBITS  pattern length in bits (2..16)
//   CNT_W  width of match_count
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   cfg_en       load cfg_pattern/cfg_mask/cfg_overlap this cycle
//   cfg_pattern  pattern, bit NBITS-1 is the oldest bit, bit 0 the newest
//   cfg_mask     per-bit compare enable (1 = compare, 0 = don't care)
//   cfg_overlap  1 = overlapping matches allowed, 0 = history dropped on match
//   in_val       in_ carries a valid stream bit this cycle
//   in_          serial stream bit
//   count_clr    synchronous clear of match_count
//   out          combinational match pulse
//   match_count  saturating number of matches since reset/clear

module seq_pattern_detector #(
  parameter int NBITS = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic [NBITS-1:0] cfg_pattern,
  input  logic [NBITS-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             in_val,
  input  logic             in_,
  input  logic             count_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W   = $clog2(NBITS);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NBITS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NBITS-1:0]  PAT_RST  = {{(NBITS-1){1'b1}}, 1'b0};

  logic [NBITS-1:0]  r_pat;
  logic [NBITS-1:0]  r_msk;
  logic              r_ovl;
  logic [NBITS-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_count;

  logic [NBITS-1:0]  w_win;
  logic              w_full;
  logic              w_accept;
  logic              w_match;

  // Match evaluation. The window is the stored history with the live bit
  // appended as the newest position, so a match is flagged in the same cycle
  // the completing bit arrives. A config cycle never matches, and nothing can
  // match until a full window of history has been accepted.
  always_comb begin
    w_win    = {r_hist, in_};
    w_full   = (r_fill == FILL_MAX);
    w_accept = in_val & ~cfg_en;
    w_match  = w_accept & w_full & (((w_win ^ r_pat) & r_msk) == '0);
  end

  assign out         = w_match;
  assign match_count = r_count;

  // Configuration registers. The reset pattern is all ones with a trailing
  // zero so the block detects a recognisable marker straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat <= PAT_RST;
      r_msk <= '1;
      r_ovl <= 1'b1;
    end else if (cfg_en) begin
      r_pat <= cfg_pattern;
      r_msk <= cfg_mask;
      r_ovl <= cfg_overlap;
    end
  end

  // Bit history and fill level. A config load restarts the history so the
  // new pattern is never compared against bits collected under the old one.
  // In non-overlap mode a match also restarts it, so the matched bits cannot
  // contribute to a following match. Cycles without a valid bit leave the
  // history untouched, which makes gaps in the stream transparent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_en) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (in_val) begin
      if (w_match && !r_ovl) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_win[NBITS-2:0];
        r_fill <= w_full ? r_fill : r_fill + 1'b1;
      end
    end
  end

  // Match counter. A clear wins over a simultaneous match, and the count
  // sticks at its maximum rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (count_clr) begin
      r_count <= '0;
    end else if (w_match && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector
//
// Purpose:
//   Directed, self-checking bench for seq_pattern_detector (NBITS=4, CNT_W=2).
//   The driver pushes the expected out value for every cycle it drives; an
//   independent monitor pops and compares on the falling edge. Counter values
//   are checked at chosen points against hand-computed constants.

module tb_seq_pattern_detector;

  localparam int NBITS = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic             cfg_en;
  logic [NBITS-1:0] cfg_pattern;
  logic [NBITS-1:0] cfg_mask;
  logic             cfg_overlap;
  logic             in_val;
  logic             in_;
  logic             count_clr;
  logic             out;
  logic [CNT_W-1:0] match_count;

  typedef struct {
    int   step;
    logic expOut;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;
  int  stepNum  = 0;

  seq_pattern_detector #(
    .NBITS(NBITS),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_en     (cfg_en),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_overlap(cfg_overlap),
    .in_val     (in_val),
    .in_        (in_),
    .count_clr  (count_clr),
    .out        (out),
    .match_count(match_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every driven cycle has exactly one queued expectation, compared
  // mid-cycle. Undriven cycles must never show a match pulse.
  always @(negedge clk) begin
    expT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (out !== e.expOut) begin
        failures++;
        $display("[TB] FAIL out step=%0d actual=%b expected=%b", e.step, out, e.expOut);
      end
    end else begin
      checks++;
      if (out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_out t=%0t actual=%b expected=0", $time, out);
      end
    end
  end

  // Drive one stream cycle and record the expected match pulse for it.
  task automatic applyStimulus(input logic v, input logic b, input logic clr,
                               input logic expOut);
    expT e;
    @(posedge clk);
    #1;
    cfg_en    = 1'b0;
    in_val    = v;
    in_       = b;
    count_clr = clr;
    stepNum++;
    e.step   = stepNum;
    e.expOut = expOut;
    expQ.push_back(e);
  endtask

  // Config cycle with a valid bit present, which must be ignored.
  task automatic applyConfig(input logic [NBITS-1:0] pat,
                             input logic [NBITS-1:0] msk, input logic ovl);
    expT e;
    @(posedge clk);
    #1;
    cfg_en      = 1'b1;
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_overlap = ovl;
    in_val      = 1'b1;
    in_         = 1'b1;
    count_clr   = 1'b0;
    stepNum++;
    e.step   = stepNum;
    e.expOut = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    cfg_en    = 1'b0;
    in_val    = 1'b0;
    in_       = 1'b0;
    count_clr = 1'b0;
  endtask

  // Feed a bit string (MSB first) with its expected out pulses.
  task automatic applyBits(input int n, input logic [31:0] bits,
                           input logic [31:0] exps);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i], 1'b0, exps[i]);
  endtask

  task automatic checkOutput(input string name, input logic [CNT_W-1:0] expCount);
    idleCycle();
    checks++;
    if (match_count !== expCount) begin
      failures++;
      $display("[TB] FAIL %s match_count actual=%0d expected=%0d", name, match_count, expCount);
    end
  endtask

  // Asynchronous reset pulse, checked while still asserted.
  task automatic doReset(input string name);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    cfg_en    = 1'b0;
    in_val    = 1'b0;
    count_clr = 1'b0;
    #2;
    checks++;
    if (out !== 1'b0 || match_count !== '0) begin
      failures++;
      $display("[TB] FAIL %s reset_state actual out=%b count=%0d expected out=0 count=0",
               name, out, match_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    cfg_en      = 1'b0;
    cfg_pattern = '0;
    cfg_mask    = '0;
    cfg_overlap = 1'b0;
    in_val      = 1'b0;
    in_         = 1'b0;
    count_clr   = 1'b0;
    #12;
    reset = 1'b0;

    // Reset config (1110, full mask, overlap): single match on 4th bit.
    doReset("t1");
    applyBits(4, 32'b1110, 32'b0001);
    checkOutput("t1_count", 2'd1);

    // Long run of ones then zero, twice, overlapping.
    doReset("t2");
    applyBits(10, 32'b1111101110, 32'b0000010001);
    checkOutput("t2_count", 2'd2);

    // Pattern 1010 with overlap, then without overlap.
    doReset("t3");
    applyConfig(4'b1010, 4'b1111, 1'b1);
    applyBits(6, 32'b101010, 32'b000101);
    checkOutput("t3_ovl_count", 2'd2);
    applyConfig(4'b1010, 4'b1111, 1'b0);
    applyBits(6, 32'b101010, 32'b000100);
    checkOutput("t3_noovl_count", 2'd3);

    // Masked pattern 1001/1001: outer bits only.
    doReset("t4");
    applyConfig(4'b1001, 4'b1001, 1'b1);
    applyBits(4, 32'b1101, 32'b0001);
    applyConfig(4'b1001, 4'b1001, 1'b1);
    applyBits(4, 32'b1010, 32'b0000);
    checkOutput("t4_count", 2'd1);

    // Mask all zero: every bit matches once the window is full.
    applyConfig(4'b0110, 4'b0000, 1'b1);
    applyBits(5, 32'b01011, 32'b00011);
    checkOutput("t4_msk0_count", 2'd3);

    // Gaps are transparent.
    doReset("t5");
    applyBits(2, 32'b11, 32'b00);
    idleCycle();
    idleCycle();
    idleCycle();
    applyBits(2, 32'b10, 32'b01);
    checkOutput("t5_gap_count", 2'd1);

    // Reset between bits 2 and 3 kills the partial pattern.
    doReset("t5b");
    applyBits(2, 32'b11, 32'b00);
    doReset("t5_mid");
    applyBits(2, 32'b10, 32'b00);
    checkOutput("t5_mid_count", 2'd0);

    // Counter saturation at 3, then clear racing a match.
    doReset("t6");
    applyBits(8, 32'b11101110, 32'b00010001);
    checkOutput("t6_two", 2'd2);
    applyBits(12, 32'b111011101110, 32'b000100010001);
    checkOutput("t6_sat", 2'd3);
    applyBits(3, 32'b111, 32'b000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("t6_clr", 2'd0);
    // Clear leaves history alone: 1110 again one window later.
    applyBits(4, 32'b1110, 32'b0001);
    checkOutput("t6_after_clr", 2'd1);

    idleCycle();
    idleCycle();
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending actual=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector for a 1-bit input stream.
- Pattern, don't-care mask and overlap mode are runtime-programmable.
- Raises a same-cycle (Mealy) match pulse and keeps a saturating match counter.
- Sits after serial front-end logic as a generic framing/marker detector.

Parameters:
- NBITS, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cfg_en  input  1  load cfg_pattern/cfg_mask/cfg_overlap this cycle.
- cfg_pattern  input  NBITS  pattern; bit NBITS-1 is the first (oldest) bit received, bit 0 the last.
- cfg_mask  input  NBITS  per-bit compare enable; 1 = compare, 0 = don't care.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history discarded after a match.
- in_val  input  1  in_ carries a valid stream bit this cycle.
- in_  input  1  serial stream bit.
- count_clr  input  1  synchronous clear of match_count.
- out  output  1  combinational match pulse for the current cycle.
- match_count  output  CNT_W  number of matches since reset/clear; saturating.

Behaviour:
- Config registers: pat[NBITS-1:0], msk[NBITS-1:0], ovl.
- Reset values: pat = all ones except bit 0 = 0 (1110 for NBITS=4), msk = all ones, ovl = 1.
- History state:
  - hist[NBITS-2:0] holds the last NBITS-1 accepted bits; hist[0] is the newest.
  - fill counts accepted bits, 0..NBITS-1, and saturates at NBITS-1.
  - Reset clears hist, fill and match_count.
- Window: win = {hist, in_}.
- Match condition: match = in_val & ~cfg_en & (fill == NBITS-1) & (((win ^ pat) & msk) == 0).
- out = match:
  - Combinational, zero latency.
  - 0 whenever in_val=0, cfg_en=1, or during reset.
- Accepted bit (in_val=1, cfg_en=0):
  - No match, or match with ovl=1: hist <= {hist[NBITS-3:0], in_}; fill <= min(fill+1, NBITS-1).
  - Match with ovl=0: hist <= 0, fill <= 0. The matched bits are not reused.
- in_val=0: hist and fill hold.
- cfg_en=1:
  - pat/msk/ovl load on the clock edge; hist <= 0, fill <= 0.
  - in_val is ignored that cycle; the new config applies from the next cycle.
- Counter:
  - Priority order: count_clr (-> 0) over match increment over hold.
  - Increment saturates at 2^CNT_W-1.
  - count_clr and match in the same cycle -> match_count = 0.
  - count_clr does not affect hist/fill.
- Boundary cases:
  - msk = 0: every accepted bit matches once fill has reached NBITS-1.
  - Reset asserted mid-stream: immediate clear; the first match is possible only after NBITS fresh accepted bits.
  - Gaps (in_val=0) between bits are transparent; they do not break a pattern.

Test Plan:
- Reset config, NBITS=4, stream 1,1,1,0 (in_val=1 each) -> out=1 only on the 4th bit; match_count=1.
- Reset config, stream 1,1,1,1,1,0,1,1,1,0 -> out=1 on bits 6 and 10; match_count=2.
- cfg pattern 1010, msk 1111, ovl=1, stream 1,0,1,0,1,0 -> out on bits 4 and 6. Same stream with ovl=0 -> out on bit 4 only.
- Pattern 1001, msk 1001, stream 1,1,0,1 -> match on bit 4. Stream 1,0,1,0 -> no match.
- Stream 1,1,(in_val=0 for 3 cycles),1,0 -> out=1 on final bit. Assert reset between bits 2 and 3 instead -> no match.
- CNT_W=2: 5 matches -> match_count=3. Then count_clr with a simultaneous match -> match_count=0, out=1 that cycle.
